// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the mpsoc_ahb3 master and spram slave.
package mpsoc_ahb3_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/mpsoc_ahb3_master.sv
// AHB3-Lite initiator: valid/ready request stream in, single-beat pipelined
// transfers out, one in-order response per accepted request.
module mpsoc_ahb3_master
  import mpsoc_ahb3_pkg::*;
#(
  parameter int          PLEN        = 32,
  parameter int          XLEN        = 32,
  parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PLEN-1:0] req_addr,
  input  logic            req_write,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);
  logic [XLEN-1:0] wdata_hold;
  logic            dp_valid;
  logic            dp_write;
  logic            cancel_pend;
  logic            accept;

  assign req_ready = HREADY & ~cancel_pend;
  assign accept    = req_valid & req_ready;
  assign HSEL      = HTRANS[1];
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;
  assign busy      = (HTRANS == HTRANS_NONSEQ) | dp_valid | cancel_pend | rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HTRANS      <= HTRANS_IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= '0;
      wdata_hold  <= '0;
      HWDATA      <= '0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      cancel_pend <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (HREADY) begin
        if (accept) begin
          HTRANS     <= HTRANS_NONSEQ;
          HADDR      <= req_addr;
          HWRITE     <= req_write;
          HSIZE      <= req_size;
          wdata_hold <= req_wdata;
        end else begin
          HTRANS <= HTRANS_IDLE;
        end
        dp_valid <= (HTRANS == HTRANS_NONSEQ);
        dp_write <= HWRITE;
        if (HTRANS == HTRANS_NONSEQ)
          HWDATA <= wdata_hold;
        if (dp_valid) begin
          rsp_valid <= 1'b1;
          rsp_err   <= HRESP;
          rsp_rdata <= (!dp_write && HRESP == HRESP_OKAY) ? HRDATA : '0;
        end
      end else if (dp_valid && HRESP == HRESP_ERROR && HTRANS == HTRANS_NONSEQ) begin
        // first ERROR cycle: withdraw the queued transfer, answer it later
        HTRANS      <= HTRANS_IDLE;
        cancel_pend <= 1'b1;
      end
      // error response has gone out; the withdrawn transfer answers next
      if (cancel_pend && !dp_valid) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        rsp_rdata   <= '0;
        cancel_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mpsoc_ahb3_master.sv
// Bench for mpsoc_ahb3_master: behavioural AHB slave with wait/error injection
// plus an in-order response scoreboard.
module tb_mpsoc_ahb3_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'd2;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  mpsoc_ahb3_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:255];
  logic        s_act, s_wr, s_err, s_err2;
  logic [31:0] s_addr;
  int          s_wcnt;
  int          hit104;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic [31:0] err_addr   = 32'hFFFF_FFFF;
  int          stall_n    = 0;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (s_act && s_err) begin
      HRESP  = 1'b1;
      HREADY = s_err2;
    end else if (s_act && s_wcnt != 0) begin
      HREADY = 1'b0;
    end
  end
  assign HRDATA = s_act ? mem[s_addr[9:2]] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_err2 <= 1'b0;
      s_addr <= '0; s_wcnt <= 0;
    end else if (HREADY) begin
      if (s_act && s_wr && !s_err) mem[s_addr[9:2]] <= HWDATA;
      s_act  <= HSEL && HTRANS == 2'b10;
      s_addr <= HADDR;
      s_wr   <= HWRITE;
      s_wcnt <= (HADDR == stall_addr) ? stall_n : 0;
      s_err  <= (HADDR == err_addr);
      s_err2 <= 1'b0;
      if (HSEL && HTRANS == 2'b10 && HADDR == 32'h104) hit104 <= hit104 + 1;
    end else begin
      if (s_wcnt > 0) s_wcnt <= s_wcnt - 1;
      if (s_err) s_err2 <= 1'b1;
    end
  end
  initial hit104 = 0;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   last_rsp = -10;
  int   run = 0;
  int   max_run = 0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
        if (mon_e.lat) begin
          checks++;
          if (cyc - mon_e.cyc != 3) begin
            errors++;
            $display("FAIL rsp_latency: got %0d cycles, expected 3", cyc - mon_e.cyc);
          end
        end
      end
      run = (cyc == last_rsp + 1) ? run + 1 : 1;
      last_rsp = cyc;
      if (run > max_run) max_run = run;
    end
  end

  // Drive at a negedge, wait for acceptance, then verify the address phase.
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input bit lat, input bit push);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz; req_wdata = wd;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready=%b, expected 1 within 20 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{e_err, e_rd, cyc, lat});
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== a || HWRITE !== w || HSIZE !== sz) begin
      errors++;
      $display("FAIL addr_phase: got trans=%b addr=%h write=%b size=%0d, expected 10 %h %b %0d",
               HTRANS, HADDR, HWRITE, HSIZE, a, w, sz);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0 ||
        HWRITE !== 1'b0 || HSIZE !== 3'd0) begin
      errors++;
      $display("FAIL reset_bus: got trans=%b sel=%b addr=%h wdata=%h write=%b size=%0d, expected all 0",
               HTRANS, HSEL, HADDR, HWDATA, HWRITE, HSIZE);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b busy=%b, expected all 0",
               rsp_valid, rsp_rdata, rsp_err, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    checks++;
    if (HWDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL data_phase_hwdata: got %h, expected deadbeef", HWDATA);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      issue(32'h80 + 32'(i*4), 1'b1, 3'd2, 32'hA5A5_0000 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b1);
    drain();
    max_run = 0;
    for (int i = 0; i < 4; i++)
      issue(32'h80 + 32'(i*4), 1'b0, 3'd2, 32'h0, 1'b0, 32'hA5A5_0000 + 32'(i), 1'b1, 1'b1);
    drain();
    checks++;
    if (max_run < 4) begin
      errors++;
      $display("FAIL b2b_pulses: got run of %0d consecutive responses, expected 4", max_run);
    end
  endtask

  task automatic test_wait_states();
    int stalls = 0;
    for (int i = 0; i < 3; i++)
      issue(32'h20 + 32'(i*4), 1'b1, 3'd2, 32'h1111_0000 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b1);
    drain();
    stall_addr = 32'h24; stall_n = 2;
    issue(32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1111_0000, 1'b0, 1'b1);
    issue(32'h24, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1111_0001, 1'b0, 1'b1);
    issue(32'h28, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1111_0002, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (HREADY === 1'b0) begin
        stalls++;
        checks++;
        if (req_ready !== 1'b0 || HADDR !== 32'h28 || HTRANS !== 2'b10 || HWRITE !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: got ready=%b addr=%h trans=%b write=%b, expected 0 00000028 10 0",
                   req_ready, HADDR, HTRANS, HWRITE);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (stalls != 2) begin
      errors++;
      $display("FAIL stall_count: got %0d wait cycles, expected 2", stalls);
    end
    stall_addr = 32'hFFFF_FFFF; stall_n = 0;
    drain();
  endtask

  task automatic test_error();
    err_addr = 32'h100;
    issue(32'h100, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 1'b1);
    issue(32'h104, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (HRESP !== 1'b1 || HREADY !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle1: got hresp=%b hready=%b ready=%b, expected 1 0 0", HRESP, HREADY, req_ready);
    end
    @(negedge clk);
    checks++;
    if (HTRANS !== 2'b00 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle2: got trans=%b ready=%b, expected 00 0", HTRANS, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_rsp1: got valid=%b ready=%b, expected 1 0", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_rsp2: got valid=%b ready=%b, expected 1 1", rsp_valid, req_ready);
    end
    drain();
    checks++;
    if (hit104 != 0) begin
      errors++;
      $display("FAIL err_cancel: 0x104 issued %0d times, expected 0", hit104);
    end
    err_addr = 32'hFFFF_FFFF;
    issue(32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    issue(32'h40, 1'b1, 3'd2, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_pre: got %b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0 ||
        HWRITE !== 1'b0 || HSIZE !== 3'd0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got trans=%b sel=%b addr=%h wdata=%h write=%b size=%0d valid=%b busy=%b, expected all 0",
               HTRANS, HSEL, HADDR, HWDATA, HWRITE, HSIZE, rsp_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy_post: got %b, expected 0", busy);
    end
  endtask

  task automatic test_byte_write();
    issue(32'h3, 1'b1, 3'd0, 32'h0000_00AB, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011 || HSEL !== 1'b1) begin
      errors++;
      $display("FAIL byte_ctrl: got burst=%b lock=%b prot=%b sel=%b, expected 000 0 0011 1",
               HBURST, HMASTLOCK, HPROT, HSEL);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_byte_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mpsoc_ahb3_master.md
Name: mpsoc_ahb3_master

Overview:
AHB3-Lite initiator (master) that turns a simple valid/ready request stream into single-beat AHB3-Lite transfers. It returns one response per request, in order. It is the driving end for the per-tile external AHB3 memory ports: test harnesses, DMA-style fillers and boot loaders use it to access mpsoc_ahb3_spram-class slaves. Address and data phases overlap, so back-to-back requests reach one transfer per cycle with zero-wait slaves.

Parameters:
PLEN, 32, address width
XLEN, 32, data width
HPROT_VALUE, 4'b0011, constant HPROT driven on every transfer (data, privileged)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock domain, reset asynchronous and active-high
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid and req_ready are both high
req_addr  in  PLEN  byte address
req_write  in  1  1 = write, 0 = read
req_size  in  3  HSIZE encoding, 0..log2(XLEN/8)
req_wdata  in  XLEN  write data
rsp_valid  out  1  one-cycle response pulse; no back-pressure
rsp_rdata  out  XLEN  read data; 0 for writes and errors
rsp_err  out  1  transfer ended with ERROR or was cancelled
busy  out  1  address or data phase or pending response outstanding
HSEL  out  1  equals HTRANS[1]
HADDR  out  PLEN  address-phase address
HWDATA  out  XLEN  data-phase write data
HWRITE  out  1  address-phase direction
HSIZE  out  3  address-phase size
HBURST  out  3  constant SINGLE (3'b000)
HPROT  out  4  HPROT_VALUE
HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
HMASTLOCK  out  1  constant 0
HRDATA  in  XLEN  slave read data
HREADY  in  1  slave ready; the address phase advances only when this is 1
HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values: HTRANS = IDLE, HSEL = 0, HADDR/HWDATA/HWRITE/HSIZE = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0. All pending state is cleared.
- Reset mid-transfer drops in-flight transfers with no response.
- req_ready = HREADY & ~cancel_pend. This is combinational from HREADY.
- Address-phase registers (HTRANS, HADDR, HWRITE, HSIZE, plus a held wdata copy) update only on an edge where HREADY = 1:
  - If a request is accepted, load it with HTRANS = NONSEQ.
  - Otherwise load HTRANS = IDLE.
- While HREADY = 0, every address-phase output holds steady.
- Data phase: on an edge with HREADY = 1 and HTRANS = NONSEQ, set dp_valid and dp_write, and set HWDATA = held wdata. HWDATA is stable for the whole data phase.
- Completion: on an edge with dp_valid and HREADY = 1, rsp_valid = 1 for the next cycle.
  - rsp_err = HRESP.
  - rsp_rdata = HRDATA for an OKAY read, else 0.
- Latency with a zero-wait slave:
  - Request accepted in cycle T.
  - HTRANS = NONSEQ in T+1.
  - Data phase in T+2.
  - rsp_valid in T+3.
  - Sustained throughput is one response per cycle.
- ERROR handling (two-cycle AHB response):
  - First error cycle (dp_valid, HRESP = 1, HREADY = 0): if the address phase holds NONSEQ, the next edge forces HTRANS = IDLE, sets cancel_pend, and the held transfer is never issued.
  - Second error cycle (HREADY = 1): the error response is produced as under Completion, with rsp_err = 1.
  - The cancelled transfer's response comes in the cycle after that, with rsp_err = 1 and rsp_rdata = 0. cancel_pend then clears.
  - Responses stay strictly in request order: exactly one per accepted request.
- Simultaneous completion and acceptance in the same cycle is legal. The data phase reloads from the address phase.
- busy = (HTRANS == NONSEQ) | dp_valid | cancel_pend | rsp_valid.

Decomposition:
- Shared package mpsoc_ahb3_pkg holds:
  - HTRANS_IDLE / BUSY / NONSEQ / SEQ
  - HBURST_SINGLE
  - HSIZE_BYTE / HWORD / WORD / DWORD
  - HRESP_OKAY / ERROR
- The matching slave (mpsoc_ahb3_spram) uses the same package.
- Single module; no sub-module is natural.

Test Plan:
- Write 0x0000_0010 = 0xDEADBEEF, then read 0x10, against a zero-wait spram -> read rsp_rdata = 0xDEADBEEF, rsp_err = 0; each rsp_valid arrives 3 cycles after acceptance.
- Four back-to-back reads with req_valid held high -> HTRANS = NONSEQ on 4 consecutive cycles; 4 consecutive rsp_valid pulses in order.
- Slave inserts 2 wait states (HREADY = 0) on the second of two reads -> HADDR, HTRANS and HWRITE stay stable while stalled; req_ready = 0 while HREADY = 0; responses in order.
- ERROR on a write to 0x100 with a read to 0x104 pipelined behind it:
  - HTRANS goes IDLE after the first error cycle and 0x104 is never issued.
  - Two responses, both with rsp_err = 1 and rsp_rdata = 0.
  - req_ready = 0 until the cancelled response has been emitted.
- Assert rst for 1 cycle during a data phase -> all outputs return to reset values asynchronously; no rsp_valid for the dropped transfer; busy = 0.
- Byte write (req_size = 0) to 0x3 -> HSIZE = 0, HADDR = 0x3, HBURST = 0, HMASTLOCK = 0, HPROT = 4'b0011.
